// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input; built only with UART_RX_SYNC_EN.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync (
  input  logic bclk,
  input  logic rst,
  input  logic rx_data,
  output logic rx_sync
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], rx_data};

  // Reset to the idle (high) line level so no spurious start is seen.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= sync_d;
  end

  assign rx_sync = sync_q[1];

endmodule
`endif

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (start, DATA_BITS LSB-first, one stop bit).
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 rx_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] RBR,
  output logic                 rx_ready,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rbr_q, rbr_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 armed_q, armed_d;
  logic                 line, line_ok;
  logic                 busy, sample_bit, frame_done;

`ifdef UART_RX_SYNC_EN
  logic [1:0] settle_q, settle_d;

  uart_rx_sync u_sync (
    .bclk    (bclk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_sync (line)
  );

  // The synchronizer's reset value is not a real sample of the line, so
  // arming waits until both stages hold genuine samples.
  always_comb settle_d = {settle_q[0], 1'b1};

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) settle_q <= '0;
    else      settle_q <= settle_d;
  end

  assign line_ok = settle_q[1];
`else
  assign line    = rx_data;
  assign line_ok = 1'b1;
`endif

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (armed_q && !line) state_d = START;
      START: if (tick_q == HALF_TICK) state_d = line ? IDLE : DATA;
      DATA:  if (tick_q == LAST_TICK && bit_q == LAST_BIT) state_d = STOP;
      STOP:  if (tick_q == LAST_TICK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    sample_bit = (state_q == DATA) && (tick_q == LAST_TICK);
    frame_done = (state_q == STOP) && (tick_q == LAST_TICK);
  end

  always_comb begin
    tick_d = (!busy || tick_q == LAST_TICK || state_d != state_q) ? '0 : tick_q + 1'b1;
    bit_d  = (state_q == DATA) ? (sample_bit ? bit_q + 1'b1 : bit_q) : '0;

    shift_d = shift_q;
    if (sample_bit) shift_d[bit_q] = line;

    armed_d = armed_q | (line & line_ok);

    rbr_d  = frame_done ? shift_q : rbr_q;
    ferr_d = frame_done ? ~line : ferr_q;

    // A completion wins over a simultaneous read, and that read also
    // acknowledges any earlier overrun.
    ready_d = frame_done ? 1'b1 : (rd_en ? 1'b0 : ready_q);
    ovr_d   = rd_en ? 1'b0 : (ovr_q | (frame_done & ready_q));
  end

  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rbr_q   <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rbr_q   <= rbr_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      armed_q <= armed_d;
    end
  end

  assign RBR       = rbr_q;
  assign rx_ready  = ready_q;
  assign rx_status = busy;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a scoreboard of expected frames.
module tb_uart_receiver;

  localparam int unsigned OS = 16;
`ifdef UART_RX_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif
  localparam int unsigned LATENCY = 153 + SYNC_LAT;

  logic       bclk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] RBR;
  logic       rx_ready, rx_status, frame_err, overrun;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned lat;

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .bclk      (bclk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rd_en     (rd_en),
    .RBR       (RBR),
    .rx_ready  (rx_ready),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; each serial bit lasts OS bclk periods.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_data = 1'b0;
    repeat (OS) @(negedge bclk);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      repeat (OS) @(negedge bclk);
    end
    rx_data = stop_bit;
    repeat (OS) @(negedge bclk);
    rx_data = 1'b1;
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    n_checks++;
    assert (sb_q.size() > 0)
    else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rbr"}, {24'h0, RBR}, {24'h0, e.data});
      chk({tag, "_ferr"}, {31'h0, frame_err}, {31'h0, e.ferr});
      chk({tag, "_ready"}, {31'h0, rx_ready}, 32'h1);
    end
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    @(negedge bclk);
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge bclk);
    chk("rst_rbr", {24'h0, RBR}, 32'h0);
    chk("rst_ready", {31'h0, rx_ready}, 32'h0);
    chk("rst_status", {31'h0, rx_status}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge bclk);

    // 0xA5 with latency measurement from the first sampling edge
    sb_q.push_back('{data: 8'hA5, ferr: 1'b0});
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 400) begin
          @(posedge bclk);
          lat++;
          #1;
          if (rx_ready) break;
        end
      end
    join
    chk("a5_latency", lat, LATENCY);
    expect_frame("a5");
    chk("a5_idle", {31'h0, rx_status}, 32'h0);
    read_pulse();
    chk("rd_ready", {31'h0, rx_ready}, 32'h0);
    chk("rd_ovr", {31'h0, overrun}, 32'h0);

    // False start: 4 low cycles then high
    rx_data = 1'b0;
    repeat (3) @(negedge bclk);
    chk("fs_busy", {31'h0, rx_status}, 32'h1);
    @(negedge bclk);
    rx_data = 1'b1;
    repeat (20) @(negedge bclk);
    chk("fs_status", {31'h0, rx_status}, 32'h0);
    chk("fs_ready", {31'h0, rx_ready}, 32'h0);
    chk("fs_rbr", {24'h0, RBR}, 32'hA5);

    // Framing error then a good frame
    sb_q.push_back('{data: 8'h3C, ferr: 1'b1});
    send_frame(8'h3C, 1'b0);
    expect_frame("3c");
    read_pulse();
    repeat (2 * OS) @(negedge bclk);
    sb_q.push_back('{data: 8'h01, ferr: 1'b0});
    send_frame(8'h01, 1'b1);
    expect_frame("01");
    read_pulse();

    // Back-to-back frames without reading
    sb_q.push_back('{data: 8'h11, ferr: 1'b0});
    send_frame(8'h11, 1'b1);
    expect_frame("11");
    chk("11_ovr", {31'h0, overrun}, 32'h0);
    sb_q.push_back('{data: 8'h22, ferr: 1'b0});
    send_frame(8'h22, 1'b1);
    expect_frame("22");
    chk("22_ovr", {31'h0, overrun}, 32'h1);
    read_pulse();
    chk("ovr_clr_ready", {31'h0, rx_ready}, 32'h0);
    chk("ovr_clr_ovr", {31'h0, overrun}, 32'h0);

    // Reset during bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (OS * 5 + OS / 2) @(negedge bclk);
        rst = 1'b0;
        @(negedge bclk);
        chk("mid_rst_rbr", {24'h0, RBR}, 32'h0);
        chk("mid_rst_ready", {31'h0, rx_ready}, 32'h0);
        chk("mid_rst_status", {31'h0, rx_status}, 32'h0);
        @(negedge bclk);
        rst = 1'b1;
      end
    join
    repeat (4) @(negedge bclk);
    chk("after_ff_ready", {31'h0, rx_ready}, 32'h0);
    sb_q.push_back('{data: 8'h5A, ferr: 1'b0});
    send_frame(8'h5A, 1'b1);
    expect_frame("5a");

    // Read strobe on the exact completion edge while rx_ready is set
    sb_q.push_back('{data: 8'h77, ferr: 1'b0});
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (152 + SYNC_LAT) @(negedge bclk);
        rd_en = 1'b1;
        @(negedge bclk);
        rd_en = 1'b0;
      end
    join
    expect_frame("77");
    chk("77_ovr", {31'h0, overrun}, 32'h0);
    read_pulse();

    // Line held low through reset release must not start a frame
    rx_data = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge bclk);
    rst = 1'b1;
    repeat (40) @(negedge bclk);
    chk("low_rel_status", {31'h0, rx_status}, 32'h0);
    chk("low_rel_ready", {31'h0, rx_ready}, 32'h0);
    rx_data = 1'b1;
    repeat (4) @(negedge bclk);
    sb_q.push_back('{data: 8'hC3, ferr: 1'b0});
    send_frame(8'hC3, 1'b1);
    expect_frame("c3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, giving bclk cycles per serial bit (even, >= 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, giving data bits per frame.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port bclk, input, 1 bit: sampling clock at OVERSAMPLE x baud.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rx_data, input, 1 bit: serial line, idles high.
REQ-007 SHALL have port rd_en, input, 1 bit: consumer read strobe; clears rx_ready.
REQ-008 SHALL have port RBR, output, DATA_BITS: last received byte.
REQ-009 SHALL have port rx_ready, output, 1 bit: RBR holds an unread byte.
REQ-010 SHALL have port rx_status, output, 1 bit: frame reception in progress.
REQ-011 SHALL have port frame_err, output, 1 bit: stop bit of the last frame sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: a frame completed while rx_ready was already set.

Function
REQ-013 Frame format SHALL be: start bit 0, DATA_BITS data bits LSB first, one stop bit 1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP, driven by a 4-bit tick counter and a 3-bit bit counter.
REQ-015 In IDLE, sampling line=0 SHALL move to START with tick=0; otherwise the FSM stays in IDLE.
REQ-016 In START, at tick=OVERSAMPLE/2-1 the line SHALL be re-sampled: 0 -> DATA with tick=0; 1 -> false start -> IDLE, with no flags changed.
REQ-017 In DATA, at tick=OVERSAMPLE-1 the line SHALL be shifted into bit position bitcnt (LSB first); after bit DATA_BITS-1 the FSM SHALL go to STOP.
REQ-018 In STOP, at tick=OVERSAMPLE-1 the FSM SHALL, on the next edge, load RBR, set rx_ready, set frame_err to the inverse of the sampled stop bit, and return to IDLE.
REQ-019 frame_err SHALL be updated on every completed frame and SHALL hold its value until the next frame completes.
REQ-020 RBR SHALL NOT change except on frame completion, and the byte SHALL be written even when frame_err=1.
REQ-021 rx_ready SHALL clear on the edge after rd_en=1.
REQ-022 If completion and rd_en occur in the same cycle, rx_ready SHALL remain 1, RBR SHALL take the new byte and overrun SHALL NOT set.
REQ-023 If a frame completes while rx_ready=1 and rd_en=0, overrun SHALL set and RBR SHALL be overwritten; overrun is sticky and clears with rd_en.
REQ-024 rx_status SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-025 Latency SHALL be exactly OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 bclk edges from the IDLE edge that samples line=0 to rx_ready=1, which is 153 at the default parameters.
REQ-026 After STOP the FSM SHALL return to IDLE immediately, so back-to-back frames with no idle gap are received.

Reset
REQ-027 When rst=0, asynchronously: FSM=IDLE, counters=0, shift register=0, RBR=0, rx_ready=0, rx_status=0, frame_err=0, overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame, and no partial byte SHALL reach RBR.
REQ-029 After rst deasserts, a line already low SHALL be treated as a start edge only once it has been sampled high at least once.

Configuration
REQ-030 Macro UART_RX_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on rx_data, reset to 1; the FSM uses the synchronized line and all latencies measured from rx_data grow by 2 bclk.
REQ-031 Without UART_RX_SYNC_EN, the FSM SHALL sample rx_data directly, with no extra flops.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enum (IDLE/START/DATA/STOP), OVERSAMPLE_DEFAULT=16 and DATA_BITS_DEFAULT=8.
REQ-033 The synchronizer SHALL be the sub-module uart_rx_sync, instantiated only under UART_RX_SYNC_EN.

Verification
REQ-034 Frame for 0xA5 at 16x, no rd_en -> rx_ready=1 after 153 edges (155 with sync), RBR=0xA5, frame_err=0.
REQ-035 Line low for 4 bclk, then high -> no state past START, rx_ready=0, RBR unchanged.
REQ-036 Frame for 0x3C with stop bit=0 -> RBR=0x3C, rx_ready=1, frame_err=1; a following good frame 0x01 -> frame_err=0.
REQ-037 Frames 0x11 then 0x22 back-to-back, no rd_en -> RBR=0x22, overrun=1; rd_en pulse -> rx_ready=0, overrun=0.
REQ-038 rst=0 during bit 4 of 0xFF, then release and send 0x5A -> RBR=0x5A with no corruption, rx_ready=1.
REQ-039 rd_en on the exact completion edge of frame 0x77 while rx_ready=1 -> rx_ready=1, RBR=0x77, overrun=0.
